// File: rtl/matmul_stream_io.sv
// rtl/matmul_stream_io.sv - stream loader/unloader around the packed float matrix multiplier
// Collects A then B row-major, fires the multiplier, then streams the result row-major.
module matmul_stream_io #(
  parameter int S       = 32,
  parameter int H       = 2,
  parameter int C       = 2,
  parameter int W       = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [S-1:0]     in_data,
  output logic [S*H*C-1:0] mm_a,
  output logic [S*C*W-1:0] mm_b,
  output logic             mm_start,
  input  logic             mm_done,
  input  logic [S*H*W-1:0] mm_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [S-1:0]     out_data,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  localparam int NA   = H * C;
  localparam int NB   = C * W;
  localparam int NO   = H * W;
  localparam int M1   = (NA > NB) ? NA : NB;
  localparam int M2   = (M1 > NO) ? M1 : NO;
  localparam int MAXN = (M2 > TIMEOUT) ? M2 : TIMEOUT;
  localparam int CW   = $clog2(MAXN + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD_A, ST_LOAD_B, ST_FIRE, ST_WAIT, ST_DRAIN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic            err_q, err_d;
  logic            cap;
  logic [S*NO-1:0] res_q;

  // Multiplier operand layout: A stored column-major, B stored column-major, both slot-reversed.
  function automatic int a_slot(input int n);
    return NA - 1 - ((n % C) * H + n / C);
  endfunction

  function automatic int b_slot(input int n);
    return NB - 1 - ((n % W) * C + n / W);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    err_d   = 1'b0;
    cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD_A;
        cnt_d   = '0;
      end
      ST_LOAD_A: begin
        if (in_valid) begin
          if (cnt_q == CW'(NA - 1)) begin
            state_d = ST_LOAD_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD_B: begin
        if (in_valid) begin
          if (cnt_q == CW'(NB - 1)) begin
            state_d = ST_FIRE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FIRE: begin
        state_d = ST_WAIT;
        timer_d = '0;
      end
      ST_WAIT: begin
        // timer_q==0 marks the first WAIT cycle, where a done left over from the last job is ignored
        if (timer_q != '0 && mm_done) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
          cap     = 1'b1;
        end else if (timer_q == CW'(TIMEOUT - 1)) begin
          state_d = ST_LOAD_A;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (out_ready) begin
          if (cnt_q == CW'(NO - 1)) begin
            state_d = ST_LOAD_A;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    mm_start  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = (state_q != ST_IDLE);
    err       = err_q;
    case (state_q)
      ST_LOAD_A, ST_LOAD_B: in_ready = 1'b1;
      ST_FIRE:              mm_start = 1'b1;
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == CW'(NO - 1));
        for (int n = 0; n < NO; n++)
          if (cnt_q == CW'(n)) out_data = res_q[S*(NO-1-n) +: S];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_a  <= '0;
      mm_b  <= '0;
      res_q <= '0;
    end else begin
      for (int n = 0; n < NA; n++)
        if (state_q == ST_LOAD_A && in_valid && cnt_q == CW'(n))
          mm_a[S*a_slot(n) +: S] <= in_data;
      for (int n = 0; n < NB; n++)
        if (state_q == ST_LOAD_B && in_valid && cnt_q == CW'(n))
          mm_b[S*b_slot(n) +: S] <= in_data;
      if (cap) res_q <= mm_o;
    end
  end

endmodule

// File: tb/tb_matmul_stream_io.sv
// tb/tb_matmul_stream_io.sv - self-checking bench for matmul_stream_io with a stub multiplier
module tb_matmul_stream_io;

  localparam int H = 2, C = 2, W = 2, TO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic [127:0] mm_a, mm_b, mm_o;
  logic         mm_start, mm_done;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic         out_last, busy, err;

  logic         stub_en = 1'b1, stub_fp = 1'b0, stub_done = 1'b0, man_done = 1'b0;
  logic [127:0] stub_o = '0, man_o = '0;
  int           stub_delay = 0;
  int           total = 0, bad = 0;
  logic [31:0]  ja [4];
  logic [31:0]  jb [4];
  logic [31:0]  jexp [4];

  assign mm_done = stub_en ? stub_done : man_done;
  assign mm_o    = stub_en ? stub_o : man_o;

  always #5 clk = ~clk;

  matmul_stream_io #(.S(32), .H(H), .C(C), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mm_a(mm_a), .mm_b(mm_b), .mm_start(mm_start), .mm_done(mm_done), .mm_o(mm_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .err(err)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int f2i(input logic [31:0] f);
    int e;
    logic [31:0] m;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    m = {8'd0, 1'b1, f[22:0]};
    return int'(m >> (23 - e));
  endfunction

  function automatic logic [31:0] i2f(input int v);
    int p;
    logic [31:0] sh;
    if (v == 0) return 32'd0;
    p = 0;
    for (int b = 0; b < 24; b++) if (v[b]) p = b;
    sh = 32'(v << (23 - p));
    return {1'b0, 8'(127 + p), sh[22:0]};
  endfunction

  // Multiplier stand-in: reads operands using the documented slot layout.
  function automatic logic [127:0] stub_mul(input logic [127:0] a, input logic [127:0] b, input logic fp);
    logic [127:0] r;
    logic [31:0]  ae, be, acc;
    int           facc;
    r = '0;
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) begin
        acc = '0;
        facc = 0;
        for (int k = 0; k < C; k++) begin
          ae = a[32*(H*C-1-(k*H+i)) +: 32];
          be = b[32*(C*W-1-(j*C+k)) +: 32];
          acc += ae * be;
          facc += f2i(ae) * f2i(be);
        end
        r[32*(H*W-1-(i*W+j)) +: 32] = fp ? i2f(facc) : acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] pack_a();
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < H; i++)
      for (int k = 0; k < C; k++) r[32*(H*C-1-(k*H+i)) +: 32] = ja[i*C+k];
    return r;
  endfunction

  function automatic logic [127:0] pack_b();
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < C; k++)
      for (int j = 0; j < W; j++) r[32*(C*W-1-(j*C+k)) +: 32] = jb[k*W+j];
    return r;
  endfunction

  task automatic rand_data();
    logic [31:0] acc;
    for (int e = 0; e < 4; e++) begin
      ja[e] = $urandom;
      jb[e] = $urandom;
    end
    for (int i = 0; i < H; i++)
      for (int j = 0; j < W; j++) begin
        acc = '0;
        for (int k = 0; k < C; k++) acc += ja[i*C+k] * jb[k*W+j];
        jexp[i*W+j] = acc;
      end
  endtask

  task automatic set_t1_data();
    ja = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    jb = '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    jexp = '{32'h41980000, 32'h41B00000, 32'h422C0000, 32'h42480000};
  endtask

  task automatic push(input logic [31:0] d, input bit first);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", in_ready, 1'b1);
    if (!first) chk("no_bubble", n, 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data = $urandom;
  endtask

  task automatic load(input bit toggle);
    for (int e = 0; e < 8; e++) begin
      push(e < 4 ? ja[e] : jb[e-4], e == 0);
      if (toggle && e != 7) @(negedge clk);
    end
  endtask

  task automatic fire(input bit junk);
    int n;
    n = 0;
    while (!mm_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mm_start", mm_start, 1'b1);
    chk("fire_in_ready", in_ready, 1'b0);
    chk("fire_mm_a", mm_a, pack_a());
    chk("fire_mm_b", mm_b, pack_b());
    in_valid = junk;
    in_data = $urandom;
    @(negedge clk);
    chk("start_one_cycle", mm_start, 1'b0);
  endtask

  task automatic drain(input int stall_idx);
    for (int e = 0; e < 4; e++) begin
      int n;
      n = 0;
      while (!out_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("out_valid", out_valid, 1'b1);
      chk("out_data", out_data, jexp[e]);
      chk("out_last", out_last, e == 3);
      if (e == 0) begin
        chk("drain_mm_a", mm_a, pack_a());
        chk("drain_mm_b", mm_b, pack_b());
      end
      if (e == stall_idx)
        repeat (3) begin
          @(negedge clk);
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_data", out_data, jexp[e]);
        end
      if (e == 3) in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    chk("post_drain_valid", out_valid, 1'b0);
    chk("post_drain_ready", in_ready, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_mm_start"}, mm_start, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_mm_a"}, mm_a, 128'd0);
    chk({tag, "_mm_b"}, mm_b, 128'd0);
  endtask

  task automatic job(input bit fp, input int delay, input int stall, input bit toggle, input bit junk);
    stub_fp = fp;
    stub_delay = delay;
    load(toggle);
    fire(junk);
    drain(stall);
  endtask

  initial begin
    int cd;
    bit armed;
    armed = 1'b0;
    cd = 0;
    forever begin
      @(negedge clk);
      if (mm_start) begin
        stub_done = 1'b0;
        armed = 1'b1;
        cd = stub_delay;
      end else if (armed) begin
        if (cd == 0) begin
          stub_done = 1'b1;
          stub_o = stub_mul(mm_a, mm_b, stub_fp);
          armed = 1'b0;
        end else begin
          cd--;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int errs, n;
    bit seen_ov;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("leave_idle_ready", in_ready, 1'b1);
    chk("leave_idle_busy", busy, 1'b1);

    // float job with the real-valued expected result
    set_t1_data();
    stub_fp = 1'b1;
    stub_delay = 2;
    load(1'b0);
    fire(1'b0);
    chk("t1_mm_a", mm_a, 128'h3F800000_40400000_40000000_40800000);
    drain(-1);

    // backpressure on element 1
    rand_data();
    job(1'b0, 3, 1, 1'b0, 1'b0);

    // stale done during FIRE and first WAIT cycle
    rand_data();
    stub_en = 1'b0;
    man_done = 1'b1;
    man_o = {4{32'hDEADBEEF}};
    load(1'b0);
    fire(1'b0);
    chk("stale_t0_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("stale_t1_valid", out_valid, 1'b0);
    man_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stale_low_valid", out_valid, 1'b0);
      chk("stale_low_busy", busy, 1'b1);
    end
    man_done = 1'b1;
    man_o = stub_mul(mm_a, mm_b, 1'b0);
    @(negedge clk);
    man_done = 1'b0;
    man_o = {4{32'h0BADF00D}};
    drain(-1);

    // timeout with done never raised
    rand_data();
    load(1'b0);
    fire(1'b0);
    errs = 0;
    seen_ov = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      chk("to_err", err, c == 8);
      if (c < 8) chk("to_in_ready", in_ready, 1'b0);
      if (c == 8) chk("to_reload_ready", in_ready, 1'b1);
      errs += int'(err);
      seen_ov |= out_valid;
    end
    chk("to_err_count", errs, 1);
    chk("to_no_out", seen_ov, 1'b0);
    stub_en = 1'b1;

    // toggled in_valid during load, junk in FIRE/WAIT
    rand_data();
    job(1'b0, 4, -1, 1'b1, 1'b1);

    // reset while waiting
    rand_data();
    stub_delay = 6;
    load(1'b0);
    fire(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_wait_reload", in_ready, 1'b1);

    // reset in mid-drain
    rand_data();
    stub_delay = 1;
    load(1'b0);
    fire(1'b0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("md_valid0", out_valid, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("md_data1", out_data, jexp[1]);
    rst_n = 1'b0;
    #1;
    check_zero("rst_drain");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_drain_reload", in_ready, 1'b1);

    set_t1_data();
    job(1'b1, 0, -1, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      rand_data();
      job(1'b0, $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
